dap_ap_sched: RTL and testbench

Sits between the JTAG debug port's AP request interface and NUM_AP access ports (MEM-AP, APB-AP, ...). Accepts one AP transaction per `ap_upd` pulse and decodes `ap_sel`. It then runs a req/ready handshake to the selected AP, holding `ap_busy` (WAIT response) until completion. It returns rdata and a sticky slave error, and adds a hang timeout, an abort path and overrun detection.

---
 rtl/dap_pkg.sv | 26 ++
 rtl/dap_ap_timer.sv | 37 +++
 rtl/dap_ap_sched.sv | 153 +++++++++++++++
 tb/tb_dap_ap_sched.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/dap_pkg.sv
// rtl/dap_pkg.sv - shared DAP types and constants
//
// Purpose: response codes, the fill value for failed reads, the AP scheduler
// state encoding and the latched AP request record. The DP imports this
// package too.
// Ports: none (package).

package dap_pkg;

   localparam logic [2:0]  RESP_OK_FAULT = 3'h2;
   localparam logic [2:0]  RESP_WAIT     = 3'h1;
   localparam logic [31:0] UNPREDICTABLE = 32'hdead_dead;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RAZ  = 2'd2
   } ap_sched_state_e;

   typedef struct packed {
      logic [5:0]  addr;
      logic [31:0] wdata;
      logic        write;
   } ap_req_t;

endpackage

// File: rtl/dap_ap_timer.sv
// rtl/dap_ap_timer.sv - saturating hang timer for the AP scheduler
//
// Purpose: counts cycles while enabled, clears on demand, and flags expiry
// once the count reaches TIMEOUT-1. The count stops at expiry and never wraps.
// Ports:
//   clk, rstn  clock and asynchronous active-low reset
//   clr        force count to zero (takes priority over en)
//   en         advance count by one
//   expired    count == TIMEOUT-1

module dap_ap_timer #(
   parameter int TIMEOUT = 1024
) (
   input  logic clk,
   input  logic rstn,
   input  logic clr,
   input  logic en,
   output logic expired
);

   localparam int W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

   logic [W-1:0] count;

   assign expired = (count == W'(TIMEOUT - 1));

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (en && !expired) begin
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/dap_ap_sched.sv
// rtl/dap_ap_sched.sv - DP-to-AP transaction scheduler
//
// Purpose: accepts one AP transaction per ap_upd, runs a req/ready handshake
// to the selected AP (or reads-as-zero for unimplemented selects), reports
// WAIT while busy, and returns read data plus sticky error and overrun flags.
// A hung access is force-completed after TIMEOUT cycles; ap_abort cancels it.
// Ports:
//   clk, rstn                       clock, asynchronous active-low reset
//   ap_upd/ap_sel/ap_addr/
//   ap_wdata/ap_rnw                 transaction from the DP
//   ap_abort, ap_clr_err            cancel access / clear sticky flags
//   ap_busy, ap_ack, ap_rdata,
//   ap_slverr, ap_orun              status back to the DP
//   m_req/m_addr/m_wdata/m_write    request to the APs (m_req one-hot)
//   m_ready/m_rdata/m_slverr        per-AP completion

module dap_ap_sched
   import dap_pkg::*;
#(
   parameter int NUM_AP  = 2,
   parameter int TIMEOUT = 1024
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic                  ap_upd,
   input  logic [7:0]            ap_sel,
   input  logic [5:0]            ap_addr,
   input  logic [31:0]           ap_wdata,
   input  logic                  ap_rnw,
   input  logic                  ap_abort,
   input  logic                  ap_clr_err,
   output logic                  ap_busy,
   output logic [31:0]           ap_rdata,
   output logic                  ap_slverr,
   output logic [2:0]            ap_ack,
   output logic                  ap_orun,
   output logic [NUM_AP-1:0]     m_req,
   output logic [5:0]            m_addr,
   output logic [31:0]           m_wdata,
   output logic                  m_write,
   input  logic [NUM_AP-1:0]     m_ready,
   input  logic [32*NUM_AP-1:0]  m_rdata,
   input  logic [NUM_AP-1:0]     m_slverr
);

   localparam logic [8:0] NUM_AP_W = 9'(NUM_AP);

   ap_sched_state_e state, state_nxt;
   ap_req_t         req_q;
   logic [7:0]      sel_q;
   logic            sel_valid;
   logic            sel_ready;
   logic            sel_err;
   logic [31:0]     sel_rdata;
   logic            expired;
   logic            slverr_set;
   logic            orun_set;
   logic [31:0]     rdata_nxt;

   assign m_addr    = req_q.addr;
   assign m_wdata   = req_q.wdata;
   assign m_write   = req_q.write;
   assign sel_valid = ({1'b0, ap_sel} < NUM_AP_W);

   dap_ap_timer #(.TIMEOUT(TIMEOUT)) u_timer (
      .clk     (clk),
      .rstn    (rstn),
      .clr     (state != WAIT),
      .en      (state == WAIT),
      .expired (expired)
   );

   // Completion inputs of the selected AP only; other APs are ignored.
   always_comb begin
      sel_ready = 1'b0;
      sel_err   = 1'b0;
      sel_rdata = '0;
      for (int i = 0; i < NUM_AP; i++) begin
         if (sel_q == 8'(i)) begin
            sel_ready = m_ready[i];
            sel_err   = m_slverr[i];
            sel_rdata = m_rdata[32*i +: 32];
         end
      end
   end

   // State register
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) state <= IDLE;
      else       state <= state_nxt;
   end

   // Next-state logic; in WAIT ready beats abort beats timeout.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (ap_upd) state_nxt = sel_valid ? WAIT : RAZ;
         WAIT:    if (sel_ready || ap_abort || expired) state_nxt = IDLE;
         RAZ:     state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Outputs decoded from state; reset drops m_req immediately.
   always_comb begin
      ap_busy = (state != IDLE);
      ap_ack  = ap_busy ? RESP_WAIT : RESP_OK_FAULT;
      m_req   = '0;
      for (int i = 0; i < NUM_AP; i++) begin
         m_req[i] = (state == WAIT) && (sel_q == 8'(i));
      end
   end

   // Result and sticky-flag updates on completion.
   always_comb begin
      rdata_nxt  = ap_rdata;
      slverr_set = 1'b0;
      orun_set   = ap_upd && (state != IDLE);
      if (state == WAIT) begin
         if (sel_ready) begin
            if (!req_q.write) rdata_nxt = sel_rdata;
            slverr_set = sel_err;
         end else if (!ap_abort && expired) begin
            if (!req_q.write) rdata_nxt = UNPREDICTABLE;
            slverr_set = 1'b1;
         end
      end else if (state == RAZ) begin
         if (!req_q.write) rdata_nxt = '0;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         req_q     <= '0;
         sel_q     <= '0;
         ap_rdata  <= '0;
         ap_slverr <= 1'b0;
         ap_orun   <= 1'b0;
      end else begin
         if (state == IDLE && ap_upd) begin
            req_q.addr  <= ap_addr;
            req_q.wdata <= ap_wdata;
            req_q.write <= ~ap_rnw;
            sel_q       <= ap_sel;
         end
         ap_rdata  <= rdata_nxt;
         // A set in the same cycle as a clear wins.
         ap_slverr <= slverr_set | (ap_slverr & ~ap_clr_err);
         ap_orun   <= orun_set   | (ap_orun   & ~ap_clr_err);
      end
   end

endmodule

// File: tb/tb_dap_ap_sched.sv
// tb/tb_dap_ap_sched.sv - directed self-checking bench for dap_ap_sched

module tb_dap_ap_sched;

   localparam int NUM_AP  = 2;
   localparam int TIMEOUT = 16;

   logic        clk = 1'b0;
   logic        rstn;
   logic        ap_upd;
   logic [7:0]  ap_sel;
   logic [5:0]  ap_addr;
   logic [31:0] ap_wdata;
   logic        ap_rnw;
   logic        ap_abort;
   logic        ap_clr_err;
   logic        ap_busy;
   logic [31:0] ap_rdata;
   logic        ap_slverr;
   logic [2:0]  ap_ack;
   logic        ap_orun;
   logic [1:0]  m_req;
   logic [5:0]  m_addr;
   logic [31:0] m_wdata;
   logic        m_write;
   logic [1:0]  m_ready;
   logic [63:0] m_rdata;
   logic [1:0]  m_slverr;

   int tests = 0;
   int fails = 0;

   dap_ap_sched #(.NUM_AP(NUM_AP), .TIMEOUT(TIMEOUT)) dut (
      .clk        (clk),
      .rstn       (rstn),
      .ap_upd     (ap_upd),
      .ap_sel     (ap_sel),
      .ap_addr    (ap_addr),
      .ap_wdata   (ap_wdata),
      .ap_rnw     (ap_rnw),
      .ap_abort   (ap_abort),
      .ap_clr_err (ap_clr_err),
      .ap_busy    (ap_busy),
      .ap_rdata   (ap_rdata),
      .ap_slverr  (ap_slverr),
      .ap_ack     (ap_ack),
      .ap_orun    (ap_orun),
      .m_req      (m_req),
      .m_addr     (m_addr),
      .m_wdata    (m_wdata),
      .m_write    (m_write),
      .m_ready    (m_ready),
      .m_rdata    (m_rdata),
      .m_slverr   (m_slverr)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic start(input logic [7:0] sel, input logic rnw,
                        input logic [5:0] addr, input logic [31:0] wdata);
      ap_upd   = 1'b1;
      ap_sel   = sel;
      ap_rnw   = rnw;
      ap_addr  = addr;
      ap_wdata = wdata;
   endtask

   initial begin
      rstn = 1'b0; ap_upd = 0; ap_sel = 0; ap_addr = 0; ap_wdata = 0; ap_rnw = 0;
      ap_abort = 0; ap_clr_err = 0; m_ready = 0; m_rdata = '0; m_slverr = 0;
      #12;
      check("rst_busy",   32'(ap_busy),   32'h0);
      check("rst_ack",    32'(ap_ack),    32'h2);
      check("rst_req",    32'(m_req),     32'h0);
      check("rst_rdata",  ap_rdata,       32'h0);
      check("rst_slverr", 32'(ap_slverr), 32'h0);
      check("rst_orun",   32'(ap_orun),   32'h0);
      check("rst_write",  32'(m_write),   32'h0);
      rstn = 1'b1;
      step();

      // 1: write to AP0, ready in cycle 3; a stray AP1 ready is ignored
      start(8'h0, 1'b0, 6'h3, 32'h1234_5678);
      step();                                   // cycle 1
      ap_upd = 0;
      check("t1_req_c1",  32'(m_req),   32'h1);
      check("t1_busy_c1", 32'(ap_busy), 32'h1);
      check("t1_ack_c1",  32'(ap_ack),  32'h1);
      check("t1_write",   32'(m_write), 32'h1);
      check("t1_addr",    32'(m_addr),  32'h3);
      check("t1_wdata",   m_wdata,      32'h1234_5678);
      m_ready = 2'b10;
      step();                                   // cycle 2
      check("t1_req_c2",  32'(m_req),   32'h1);
      check("t1_busy_c2", 32'(ap_busy), 32'h1);
      m_ready = 2'b00;
      step();                                   // cycle 3
      check("t1_req_c3",  32'(m_req),   32'h1);
      check("t1_wdata_c3", m_wdata,     32'h1234_5678);
      m_ready = 2'b01;
      step();                                   // cycle 4
      m_ready = 0;
      check("t1_busy_c4", 32'(ap_busy),   32'h0);
      check("t1_ack_c4",  32'(ap_ack),    32'h2);
      check("t1_req_c4",  32'(m_req),     32'h0);
      check("t1_slverr",  32'(ap_slverr), 32'h0);
      check("t1_rdata",   ap_rdata,       32'h0);

      // 2: read from AP1 with error; AP0 data must not leak through
      start(8'h1, 1'b1, 6'h10, 32'h0);
      step();
      ap_upd = 0;
      check("t2_req",   32'(m_req),   32'h2);
      check("t2_write", 32'(m_write), 32'h0);
      m_ready = 2'b10; m_slverr = 2'b10; m_rdata = {32'hcafe_f00d, 32'h1111_1111};
      step();
      m_ready = 0; m_slverr = 0;
      check("t2_rdata",  ap_rdata,       32'hcafe_f00d);
      check("t2_slverr", 32'(ap_slverr), 32'h1);
      check("t2_busy",   32'(ap_busy),   32'h0);
      step();
      check("t2_sticky", 32'(ap_slverr), 32'h1);
      ap_clr_err = 1;
      step();
      ap_clr_err = 0;
      check("t2_clr", 32'(ap_slverr), 32'h0);
      start(8'h1, 1'b1, 6'h10, 32'h0);
      step();
      ap_upd = 0;
      m_ready = 2'b10; m_slverr = 2'b10; ap_clr_err = 1;
      step();
      m_ready = 0; m_slverr = 0; ap_clr_err = 0;
      check("t2_set_wins", 32'(ap_slverr), 32'h1);
      ap_clr_err = 1;
      step();
      ap_clr_err = 0;

      // 3: unimplemented select reads as zero
      start(8'h7, 1'b1, 6'h0, 32'h0);
      step();
      ap_upd = 0;
      check("t3_req",     32'(m_req),   32'h0);
      check("t3_busy_c1", 32'(ap_busy), 32'h1);
      step();
      check("t3_busy_c2", 32'(ap_busy),   32'h0);
      check("t3_rdata",   ap_rdata,       32'h0);
      check("t3_slverr",  32'(ap_slverr), 32'h0);

      // 4: hung read to AP0 times out after TIMEOUT WAIT cycles
      start(8'h0, 1'b1, 6'h4, 32'h0);
      step();                                   // cycle 1
      ap_upd = 0;
      for (int i = 0; i < TIMEOUT - 1; i++) step();   // cycle 16
      check("t4_req_last",  32'(m_req),   32'h1);
      check("t4_busy_last", 32'(ap_busy), 32'h1);
      step();                                   // cycle 17
      check("t4_req_drop", 32'(m_req),     32'h0);
      check("t4_busy",     32'(ap_busy),   32'h0);
      check("t4_rdata",    ap_rdata,       32'hdead_dead);
      check("t4_slverr",   32'(ap_slverr), 32'h1);
      ap_clr_err = 1;
      step();
      ap_clr_err = 0;

      // 5: overrun during WAIT, then abort; then abort coincident with ready
      start(8'h0, 1'b0, 6'h5, 32'haaaa_aaaa);
      step();
      start(8'h1, 1'b1, 6'h2a, 32'h5555_5555);
      step();
      ap_upd = 0;
      check("t5_orun",  32'(ap_orun), 32'h1);
      check("t5_addr",  32'(m_addr),  32'h5);
      check("t5_wdata", m_wdata,      32'haaaa_aaaa);
      check("t5_write", 32'(m_write), 32'h1);
      check("t5_req",   32'(m_req),   32'h1);
      ap_abort = 1;
      step();
      ap_abort = 0;
      check("t5_abort_busy",  32'(ap_busy),   32'h0);
      check("t5_abort_req",   32'(m_req),     32'h0);
      check("t5_abort_err",   32'(ap_slverr), 32'h0);
      check("t5_abort_rdata", ap_rdata,       32'hdead_dead);
      check("t5_orun_sticky", 32'(ap_orun),   32'h1);
      start(8'h1, 1'b1, 6'h1, 32'h0);
      step();
      ap_upd = 0;
      ap_abort = 1; m_ready = 2'b10; m_slverr = 2'b10; m_rdata = {32'h1357_9bdf, 32'h0};
      step();
      ap_abort = 0; m_ready = 0; m_slverr = 0;
      check("t5_ar_rdata",  ap_rdata,       32'h1357_9bdf);
      check("t5_ar_slverr", 32'(ap_slverr), 32'h1);
      check("t5_ar_busy",   32'(ap_busy),   32'h0);

      // 6: asynchronous reset mid-access, then a normal access
      start(8'h0, 1'b1, 6'h8, 32'h0);
      step();
      ap_upd = 0;
      check("t6_req_pre", 32'(m_req), 32'h1);
      #2;
      rstn = 1'b0;
      #1;
      check("t6_req",    32'(m_req),     32'h0);
      check("t6_busy",   32'(ap_busy),   32'h0);
      check("t6_rdata",  ap_rdata,       32'h0);
      check("t6_slverr", 32'(ap_slverr), 32'h0);
      check("t6_orun",   32'(ap_orun),   32'h0);
      check("t6_ack",    32'(ap_ack),    32'h2);
      #3;
      rstn = 1'b1;
      step();
      start(8'h1, 1'b1, 6'h9, 32'h0);
      step();
      ap_upd = 0;
      check("t6_next_req", 32'(m_req), 32'h2);
      m_ready = 2'b10; m_rdata = {32'h0bad_f00d, 32'h0};
      step();
      m_ready = 0;
      check("t6_next_rdata", ap_rdata,     32'h0bad_f00d);
      check("t6_next_busy",  32'(ap_busy), 32'h0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
